// File: rtl/ddr_rw_arbiter.sv
// Arbitrates DDR burst commands between the camera write path and the LCD read path.
// Each side walks a frame in BURST_LEN steps within its own bank, with fair alternation on ties.
module ddr_rw_arbiter #(
  parameter int BURST_LEN     = 256,
  parameter int FRAME_WORDS   = 76800,
  parameter int RD_FIFO_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ddr_init_done,
  input  logic [10:0] wr_fifo_usedw,
  input  logic [10:0] rd_fifo_usedw,
  input  logic [1:0]  wr_bank,
  input  logic [1:0]  rd_bank,
  input  logic        wr_load,
  input  logic        rd_load,
  input  logic        cmd_ack,
  input  logic        burst_done,
  output logic        cmd_req,
  output logic        cmd_wr,
  output logic [23:0] cmd_addr,
  output logic        frame_write_done,
  output logic        frame_read_done
);

  typedef enum logic [1:0] {IDLE, ARB, REQ, BURST} state_t;

  state_t      state, state_next;
  logic        last_wr;
  logic [21:0] wr_off, rd_off;
  logic [1:0]  wr_bank_q, rd_bank_q;
  logic        wr_pend, rd_pend;

  logic        wr_elig, rd_elig, grant, grant_wr;
  logic        wr_busy, rd_busy, wr_end, rd_end, wr_apply, rd_apply;
  logic [21:0] wr_off_next, rd_off_next;

  assign wr_elig  = (int'(wr_fifo_usedw) >= BURST_LEN) && !frame_write_done;
  assign rd_elig  = ((RD_FIFO_DEPTH - int'(rd_fifo_usedw)) >= BURST_LEN) && !frame_read_done;
  // On a tie the side not granted last wins; last_wr resets to read so write wins first.
  assign grant_wr = wr_elig && (!rd_elig || !last_wr);
  assign grant    = (state == ARB) && ddr_init_done && (wr_elig || rd_elig);

  assign wr_busy  = ((state == REQ) || (state == BURST)) && cmd_wr;
  assign rd_busy  = ((state == REQ) || (state == BURST)) && !cmd_wr;
  assign wr_end   = (state == BURST) && burst_done && cmd_wr;
  assign rd_end   = (state == BURST) && burst_done && !cmd_wr;
  // A load aimed at the side in flight waits for its burst_done and then beats the increment.
  assign wr_apply = (wr_load && !wr_busy) || (wr_end && (wr_pend || wr_load));
  assign rd_apply = (rd_load && !rd_busy) || (rd_end && (rd_pend || rd_load));

  assign wr_off_next = wr_off + 22'(BURST_LEN);
  assign rd_off_next = rd_off + 22'(BURST_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ddr_init_done) state_next = ARB;
      ARB:     if (!ddr_init_done) state_next = IDLE;
               else if (grant)     state_next = REQ;
      REQ:     if (cmd_ack)        state_next = BURST;
      BURST:   if (burst_done)     state_next = ARB;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_req = (state == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr   <= 1'b0;
      cmd_addr <= 24'd0;
      last_wr  <= 1'b0;
    end else if (grant) begin
      cmd_wr   <= grant_wr;
      cmd_addr <= grant_wr ? {wr_bank_q, wr_off} : {rd_bank_q, rd_off};
      last_wr  <= grant_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_off           <= 22'd0;
      frame_write_done <= 1'b0;
      wr_bank_q        <= 2'b00;
      wr_pend          <= 1'b0;
    end else if (wr_apply) begin
      wr_off           <= 22'd0;
      frame_write_done <= 1'b0;
      wr_bank_q        <= wr_bank;
      wr_pend          <= 1'b0;
    end else begin
      if (wr_load) wr_pend <= 1'b1;
      if (wr_end) begin
        if (wr_off_next == 22'(FRAME_WORDS)) begin
          wr_off           <= 22'd0;
          frame_write_done <= 1'b1;
        end else begin
          wr_off <= wr_off_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_off          <= 22'd0;
      frame_read_done <= 1'b0;
      rd_bank_q       <= 2'b11;
      rd_pend         <= 1'b0;
    end else if (rd_apply) begin
      rd_off          <= 22'd0;
      frame_read_done <= 1'b0;
      rd_bank_q       <= rd_bank;
      rd_pend         <= 1'b0;
    end else begin
      if (rd_load) rd_pend <= 1'b1;
      if (rd_end) begin
        if (rd_off_next == 22'(FRAME_WORDS)) begin
          rd_off          <= 22'd0;
          frame_read_done <= 1'b1;
        end else begin
          rd_off <= rd_off_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Directed bench for ddr_rw_arbiter: init gating, tie alternation, deferred load,
// async reset in REQ, and a full 300-burst write frame with bank reload.
module tb_ddr_rw_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ddr_init_done;
  logic [10:0] wr_fifo_usedw;
  logic [10:0] rd_fifo_usedw;
  logic [1:0]  wr_bank;
  logic [1:0]  rd_bank;
  logic        wr_load;
  logic        rd_load;
  logic        cmd_ack;
  logic        burst_done;
  logic        cmd_req;
  logic        cmd_wr;
  logic [23:0] cmd_addr;
  logic        frame_write_done;
  logic        frame_read_done;

  int vectors = 0;
  int errors  = 0;

  ddr_rw_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ddr_init_done    (ddr_init_done),
    .wr_fifo_usedw    (wr_fifo_usedw),
    .rd_fifo_usedw    (rd_fifo_usedw),
    .wr_bank          (wr_bank),
    .rd_bank          (rd_bank),
    .wr_load          (wr_load),
    .rd_load          (rd_load),
    .cmd_ack          (cmd_ack),
    .burst_done       (burst_done),
    .cmd_req          (cmd_req),
    .cmd_wr           (cmd_wr),
    .cmd_addr         (cmd_addr),
    .frame_write_done (frame_write_done),
    .frame_read_done  (frame_read_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (cmd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, cmd_req}, 32'd1);
  endtask

  task automatic ack_and_done(input string tag);
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, cmd_req}, 32'd0);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
  endtask

  task automatic expect_grant(input string tag, input logic wr, input logic [23:0] addr);
    wait_req({tag, "_req"});
    chk({tag, "_wr"}, {31'd0, cmd_wr}, {31'd0, wr});
    chk({tag, "_addr"}, {8'd0, cmd_addr}, {8'd0, addr});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},  {31'd0, cmd_req}, 32'd0);
    chk({tag, "_wr"},   {31'd0, cmd_wr}, 32'd0);
    chk({tag, "_addr"}, {8'd0, cmd_addr}, 32'd0);
    chk({tag, "_wdone"}, {31'd0, frame_write_done}, 32'd0);
    chk({tag, "_rdone"}, {31'd0, frame_read_done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ddr_init_done = 1'b0;
    wr_fifo_usedw = 11'd0;
    rd_fifo_usedw = 11'd1024;
    wr_bank = 2'b00;
    rd_bank = 2'b11;
    wr_load = 1'b0;
    rd_load = 1'b0;
    cmd_ack = 1'b0;
    burst_done = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");

    // Both sides eligible but DDR not ready: no request may appear.
    rst_n = 1'b1;
    wr_fifo_usedw = 11'd256;
    rd_fifo_usedw = 11'd0;
    for (int i = 0; i < 6; i++) tick();
    chk("init_gate_req", {31'd0, cmd_req}, 32'd0);

    // Tie alternation starting with write.
    ddr_init_done = 1'b1;
    expect_grant("tie_w0", 1'b1, 24'h000000);
    chk("tie_w0_hold", {8'd0, cmd_addr}, 32'h000000);
    ack_and_done("tie_w0");
    expect_grant("tie_r0", 1'b0, 24'hC00000);
    ack_and_done("tie_r0");
    expect_grant("tie_w1", 1'b1, 24'h000100);
    ack_and_done("tie_w1");
    expect_grant("tie_r1", 1'b0, 24'hC00100);
    ack_and_done("tie_r1");
    expect_grant("tie_w2", 1'b1, 24'h000200);
    ack_and_done("tie_w2");
    expect_grant("tie_r2", 1'b0, 24'hC00200);

    // rd_load during the read burst must wait for burst_done.
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    wr_fifo_usedw = 11'd0;
    rd_bank = 2'b10;
    rd_load = 1'b1;
    tick();
    rd_load = 1'b0;
    tick();
    chk("midload_req", {31'd0, cmd_req}, 32'd0);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    expect_grant("midload_r", 1'b0, 24'h800000);

    // Async reset while in REQ clears outputs without waiting for a clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_in_req");
    tick();
    rd_fifo_usedw = 11'd1024;
    wr_fifo_usedw = 11'd256;
    rd_bank = 2'b11;
    rst_n = 1'b1;

    // Full write frame: 300 bursts of 256 words.
    for (int k = 0; k < 300; k++) begin
      expect_grant($sformatf("frame_w%0d", k), 1'b1, 24'(k * 256));
      ack_and_done($sformatf("frame_w%0d", k));
    end
    chk("frame_done_set", {31'd0, frame_write_done}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("frame_done_no_req", {31'd0, cmd_req}, 32'd0);

    // Stray ack / burst_done in ARB are ignored.
    cmd_ack = 1'b1;
    burst_done = 1'b1;
    tick();
    cmd_ack = 1'b0;
    burst_done = 1'b0;
    tick();
    chk("stray_pulse_req", {31'd0, cmd_req}, 32'd0);
    chk("stray_pulse_done", {31'd0, frame_write_done}, 32'd1);

    // Frame restart into bank 01.
    wr_bank = 2'b01;
    wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
    chk("reload_done_clr", {31'd0, frame_write_done}, 32'd0);
    expect_grant("reload_w", 1'b1, 24'h400000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
